median_window_gen: RTL and testbench

//   Streaming front end for the 3-input combinational median stage.

---
 rtl/median_window_gen_pkg.sv | 38 +++
 rtl/median_win_shreg.sv | 51 +++++
 rtl/median_window_gen.sv | 272 +++++++++++++++++++++++++++
 tb/tb_median_window_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/median_window_gen_pkg.sv
// Shared definitions for the median window generator: default sample
// width, FSM state encodings and a 3-input median helper used wherever a
// window needs to be reduced to its median value.
package median_window_gen_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Median of three samples (the value that is neither strictly min nor max).
    function automatic logic [DATA_W_DEF-1:0] median3(
        input logic [DATA_W_DEF-1:0] x,
        input logic [DATA_W_DEF-1:0] y,
        input logic [DATA_W_DEF-1:0] z
    );
        logic [DATA_W_DEF-1:0] lo;
        logic [DATA_W_DEF-1:0] hi;
        if (x < y) begin
            lo = x;
            hi = y;
        end else begin
            lo = y;
            hi = x;
        end
        if (z <= lo) begin
            median3 = lo;
        end else if (z >= hi) begin
            median3 = hi;
        end else begin
            median3 = z;
        end
    endfunction

endpackage

// File: rtl/median_win_shreg.sv
// Two-entry tap shift register holding the two most recent samples of the
// current line. tap_old is the older sample, tap_new the newer one.
// clr wipes both taps so a new line never sees samples of the previous one.
module median_win_shreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tap_old,
    output logic [DATA_W-1:0] tap_new
);

    logic [DATA_W-1:0] tap_old_q;
    logic [DATA_W-1:0] tap_old_d;
    logic [DATA_W-1:0] tap_new_q;
    logic [DATA_W-1:0] tap_new_d;

    // Next tap values: clear wins over shift, otherwise hold.
    always_comb begin
        tap_old_d = tap_old_q;
        tap_new_d = tap_new_q;
        if (clr) begin
            tap_old_d = {DATA_W{1'b0}};
            tap_new_d = {DATA_W{1'b0}};
        end else if (shift_en) begin
            tap_old_d = tap_new_q;
            tap_new_d = din;
        end else begin
            tap_old_d = tap_old_q;
            tap_new_d = tap_new_q;
        end
    end

    // Tap registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_old_q <= {DATA_W{1'b0}};
            tap_new_q <= {DATA_W{1'b0}};
        end else begin
            tap_old_q <= tap_old_d;
            tap_new_q <= tap_new_d;
        end
    end

    assign tap_old = tap_old_q;
    assign tap_new = tap_new_q;

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3-tap window generator feeding a combinational median stage.
// One sample is accepted per handshake; windows {a0,a1,a2} (a0 oldest) are
// presented through a single output register with valid/ready and never
// span two lines.
// Optional build macro: MEDIAN_BORDER_REPLICATE_EN -- when defined, line
// edges are replicated so every input sample yields exactly one window
// (LINE_LEN windows per line, tail window emitted from the FLUSH state).
module median_window_gen
    import median_window_gen_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LINE_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a0,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic              out_last
);

    localparam int               CNT_W    = $clog2(LINE_LEN);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_LEN - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] a0_q;
    logic [DATA_W-1:0] a0_d;
    logic [DATA_W-1:0] a1_q;
    logic [DATA_W-1:0] a1_d;
    logic [DATA_W-1:0] a2_q;
    logic [DATA_W-1:0] a2_d;
    logic              out_last_q;
    logic              out_last_d;

    logic              out_free_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              line_end_s;
    logic              load_s;
    logic [DATA_W-1:0] win_a0_s;
    logic [DATA_W-1:0] win_a1_s;
    logic [DATA_W-1:0] win_a2_s;
    logic              win_last_s;
    logic [DATA_W-1:0] tap_old_s;
    logic [DATA_W-1:0] tap_new_s;

`ifdef MEDIAN_BORDER_REPLICATE_EN
    // Tail window (x[N-2], x[N-1], x[N-1]) captured at line end, since the
    // taps are cleared on that same accept.
    logic [DATA_W-1:0] tail_a0_q;
    logic [DATA_W-1:0] tail_a0_d;
    logic [DATA_W-1:0] tail_a2_q;
    logic [DATA_W-1:0] tail_a2_d;
`endif

    // Handshake qualifiers: the output register is free when empty or draining.
    always_comb begin
        out_free_s = !out_valid_q || out_ready;
        in_ready_s = (state_q != ST_FLUSH) && out_free_s;
        accept_s   = in_valid && in_ready_s;
        line_end_s = accept_s && (cnt_q == CNT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept_s && (cnt_q == CNT_ONE)) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_STREAM: begin
                if (line_end_s) begin
`ifdef MEDIAN_BORDER_REPLICATE_EN
                    state_d = ST_FLUSH;
`else
                    state_d = ST_FILL;
`endif
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (out_free_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // FSM outputs: decide whether a window is loaded this cycle and its contents.
    always_comb begin
        load_s     = 1'b0;
        win_a0_s   = {DATA_W{1'b0}};
        win_a1_s   = {DATA_W{1'b0}};
        win_a2_s   = {DATA_W{1'b0}};
        win_last_s = 1'b0;
        case (state_q)
            ST_FILL: begin
`ifdef MEDIAN_BORDER_REPLICATE_EN
                // Second sample of the line: replicate x0 on the left edge.
                if (accept_s && (cnt_q == CNT_ONE)) begin
                    load_s   = 1'b1;
                    win_a0_s = tap_new_s;
                    win_a1_s = tap_new_s;
                    win_a2_s = in_data;
                end else begin
                    load_s = 1'b0;
                end
`else
                load_s = 1'b0;
`endif
            end
            ST_STREAM: begin
                if (accept_s) begin
                    load_s   = 1'b1;
                    win_a0_s = tap_old_s;
                    win_a1_s = tap_new_s;
                    win_a2_s = in_data;
`ifdef MEDIAN_BORDER_REPLICATE_EN
                    // The replicated tail window carries the last flag instead.
                    win_last_s = 1'b0;
`else
                    win_last_s = line_end_s;
`endif
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_FLUSH: begin
`ifdef MEDIAN_BORDER_REPLICATE_EN
                if (out_free_s) begin
                    load_s     = 1'b1;
                    win_a0_s   = tail_a0_q;
                    win_a1_s   = tail_a2_q;
                    win_a2_s   = tail_a2_q;
                    win_last_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
`else
                load_s = 1'b0;
`endif
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Next values for the line counter and the output register.
    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        a0_d        = a0_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        out_last_d  = out_last_q;
        if (accept_s) begin
            if (line_end_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (load_s) begin
            out_valid_d = 1'b1;
            a0_d        = win_a0_s;
            a1_d        = win_a1_s;
            a2_d        = win_a2_s;
            out_last_d  = win_last_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Counter and output register; contents held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= CNT_ZERO;
            out_valid_q <= 1'b0;
            a0_q        <= {DATA_W{1'b0}};
            a1_q        <= {DATA_W{1'b0}};
            a2_q        <= {DATA_W{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef MEDIAN_BORDER_REPLICATE_EN
    // Capture the tail window samples on the last accept of a line.
    always_comb begin
        if (line_end_s) begin
            tail_a0_d = tap_new_s;
            tail_a2_d = in_data;
        end else begin
            tail_a0_d = tail_a0_q;
            tail_a2_d = tail_a2_q;
        end
    end

    // Tail window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tail_a0_q <= {DATA_W{1'b0}};
            tail_a2_q <= {DATA_W{1'b0}};
        end else begin
            tail_a0_q <= tail_a0_d;
            tail_a2_q <= tail_a2_d;
        end
    end
`endif

    median_win_shreg #(
        .DATA_W(DATA_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .shift_en(accept_s && !line_end_s),
        .clr     (line_end_s),
        .din     (in_data),
        .tap_old (tap_old_s),
        .tap_new (tap_new_s)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign a0        = a0_q;
    assign a1        = a1_q;
    assign a2        = a2_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_median_window_gen.sv
// Self-checking bench for median_window_gen (LINE_LEN=4, DATA_W=8).
// A queue-based line model predicts the windows each accepted sample must
// produce; a negedge monitor compares the DUT output register against it.
// Honors MEDIAN_BORDER_REPLICATE_EN the same way the design does.
module tb_median_window_gen;
    import median_window_gen_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic       out_last;

`ifdef MEDIAN_BORDER_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]  line_q[$];   // samples of the current line (model)
    logic [31:0] exp_q[$];    // windows owed to the downstream, oldest first
    logic [31:0] obs_q[$];    // windows actually transferred (for directed tests)

    median_window_gen #(.DATA_W(8), .LINE_LEN(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .a0(a0), .a1(a1), .a2(a2), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic l, input logic [7:0] x,
                                      input logic [7:0] y, input logic [7:0] z);
        return {7'd0, l, x, y, z};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: what an accepted sample must produce, from the windowing rules.
    task automatic model_accept(input logic [7:0] d);
        int k;
        line_q.push_back(d);
        k = line_q.size() - 1;
        if (REP && k == 1)
            exp_q.push_back(w(1'b0, line_q[0], line_q[0], line_q[1]));
        if (k >= 2)
            exp_q.push_back(w((k == N - 1) && !REP, line_q[k-2], line_q[k-1], line_q[k]));
        if (REP && k == N - 1)
            exp_q.push_back(w(1'b1, line_q[k-1], line_q[k], line_q[k]));
        if (k == N - 1)
            line_q.delete();
    endtask

    // Per-cycle compare against the model, then advance the model by the coming edge.
    always @(negedge clk) begin
        int s, mx, mn;
        logic [31:0] f;
        if (rst) begin
            line_q.delete();
            exp_q.delete();
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            chk("in_ready", {31'd0, in_ready},
                {31'd0, (exp_q.size() < 2) && (!out_valid || out_ready)});
            if (out_valid && exp_q.size() != 0) begin
                f = exp_q[0];
                chk("window", w(out_last, a0, a1, a2), f);
                s  = int'(f[23:16]) + int'(f[15:8]) + int'(f[7:0]);
                mx = int'(f[23:16]);
                if (int'(f[15:8]) > mx) mx = int'(f[15:8]);
                if (int'(f[7:0]) > mx) mx = int'(f[7:0]);
                mn = int'(f[23:16]);
                if (int'(f[15:8]) < mn) mn = int'(f[15:8]);
                if (int'(f[7:0]) < mn) mn = int'(f[7:0]);
                chk("median", {24'd0, median3(a0, a1, a2)}, 32'(s - mx - mn));
                if (out_ready) begin
                    obs_q.push_back(w(out_last, a0, a1, a2));
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                model_accept(in_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=%0d expected<50", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic chk_obs(input string nm, input logic [31:0] e[], input int cnt);
        chk({nm, "_count"}, 32'(obs_q.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < obs_q.size(); i++)
            chk(nm, obs_q[i], e[i]);
    endtask

    initial begin
        logic [31:0] e[];
        logic hs;

        // Reset state
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_taps", w(1'b0, a0, a1, a2), 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1/2: single line 10,20,30,40
        obs_q.delete();
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        drain();
        if (REP) begin
            e = '{w(1'b0,8'd10,8'd10,8'd20), w(1'b0,8'd10,8'd20,8'd30),
                  w(1'b0,8'd20,8'd30,8'd40), w(1'b1,8'd30,8'd40,8'd40)};
            chk_obs("line1", e, 4);
        end else begin
            e = '{w(1'b0,8'd10,8'd20,8'd30), w(1'b1,8'd20,8'd30,8'd40)};
            chk_obs("line1", e, 2);
        end

        // 3: backpressure with a pending (1,2,3) window
        send(8'd1); send(8'd2); send(8'd3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd4;
        repeat (3) begin
            cyc();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", w(out_last, a0, a1, a2), w(1'b0, 8'd1, 8'd2, 8'd3));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next", w(out_last, a0, a1, a2), w(!REP, 8'd2, 8'd3, 8'd4));
        drain();

        // 4: back-to-back lines 1..8
        obs_q.delete();
        for (int i = 1; i <= 8; i++) send(8'(i));
        drain();
        if (REP) begin
            e = '{w(1'b0,8'd1,8'd1,8'd2), w(1'b0,8'd1,8'd2,8'd3),
                  w(1'b0,8'd2,8'd3,8'd4), w(1'b1,8'd3,8'd4,8'd4),
                  w(1'b0,8'd5,8'd5,8'd6), w(1'b0,8'd5,8'd6,8'd7),
                  w(1'b0,8'd6,8'd7,8'd8), w(1'b1,8'd7,8'd8,8'd8)};
            chk_obs("b2b", e, 8);
        end else begin
            e = '{w(1'b0,8'd1,8'd2,8'd3), w(1'b1,8'd2,8'd3,8'd4),
                  w(1'b0,8'd5,8'd6,8'd7), w(1'b1,8'd6,8'd7,8'd8)};
            chk_obs("b2b", e, 4);
        end

        // 5: reset mid-line
        send(8'd9); send(8'd8);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        obs_q.delete();
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        drain();
        chk("midrst_first", obs_q.size() > 0 ? obs_q[0] : 32'hdead,
            REP ? w(1'b0, 8'd1, 8'd1, 8'd2) : w(1'b0, 8'd1, 8'd2, 8'd3));

        // 6: random samples and random downstream readiness
        hs = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid || hs) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        drain();
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
